// File: rtl/multi_edge_pulse_pkg.sv
// Package for multi_edge_pulse.
// Holds the edge-mode encodings and a helper that decides whether an accepted
// level change produces a pulse for a given mode.
package multi_edge_pulse_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // True when an accepted change to new_level should produce a pulse in this mode.
    function automatic logic edge_fires(input int mode, input logic new_level);
        case (mode)
            EDGE_RISE: edge_fires = new_level;
            EDGE_FALL: edge_fires = ~new_level;
            default:   edge_fires = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/multi_edge_pulse_chan.sv
// edge_pulse_chan: one channel of the debounced edge-to-pulse converter.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   tick   in  qualifying strobe; the debounce counter only advances when high
//   din    in  raw asynchronous level
//   level  out debounced stable level
//   pulse  out one-clk pulse the cycle after an accepted edge matching EDGE_MODE
module edge_pulse_chan
    import multi_edge_pulse_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter int   EDGE_MODE   = EDGE_RISE,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (s == level_q) begin
            // Any agreement discards a partial count, so short glitches vanish.
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                cnt_d   = '0;
                pulse_d = edge_fires(EDGE_MODE, s);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
            cnt_q   <= '0;
            level_q <= IDLE_LEVEL;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: N-channel debounced edge-to-pulse converter.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   tick       in  qualifying strobe for debouncing
//   din        in  [CHANNELS] raw asynchronous levels
//   level      out [CHANNELS] debounced levels
//   pulse      out [CHANNELS] one-clk pulses per accepted matching edge
//   any_pulse  out OR of pulse, same cycle
module multi_edge_pulse
    import multi_edge_pulse_pkg::*;
#(
    parameter int   CHANNELS    = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter int   EDGE_MODE   = EDGE_RISE,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic                any_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_pulse_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .EDGE_MODE  (EDGE_MODE),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .din  (din[i]),
            .level(level[i]),
            .pulse(pulse[i])
        );
    end

    // pulse bits are already registered, so the OR is aligned with them.
    assign any_pulse = |pulse;

endmodule

// File: tb/tb_multi_edge_pulse.sv
module tb_multi_edge_pulse;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] level0, pulse0, level2, pulse2;
    logic          any0, any2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Rising-edge instance and both-edge instance share the stimulus.
    multi_edge_pulse #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE(DEB), .EDGE_MODE(0), .IDLE_LEVEL(1'b0)) u_rise (
        .clk(clk), .reset(rst_n), .tick(tick), .din(din),
        .level(level0), .pulse(pulse0), .any_pulse(any0));

    multi_edge_pulse #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE(DEB), .EDGE_MODE(2), .IDLE_LEVEL(1'b0)) u_both (
        .clk(clk), .reset(rst_n), .tick(tick), .din(din),
        .level(level2), .pulse(pulse2), .any_pulse(any2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a delay line of raw samples and, per channel, the number
    // of ticks the synchronised value has disagreed with the accepted level.
    logic [CH-1:0] m_pipe [SS];
    logic [CH-1:0] m_level, m_p0, m_p2;
    int            m_run [CH];

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_pipe[k] = '0;
        m_level = '0;
        m_p0 = '0;
        m_p2 = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
    endtask

    task automatic model_clk();
        logic [CH-1:0] s, acc;
        s   = m_pipe[SS-1];
        acc = '0;
        for (int c = 0; c < CH; c++) begin
            if (s[c] == m_level[c]) m_run[c] = 0;
            else if (tick) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    acc[c]   = 1'b1;
                    m_run[c] = 0;
                end
            end
        end
        m_level = (m_level & ~acc) | (s & acc);
        m_p0 = acc & m_level;   // rising: new level is 1
        m_p2 = acc;             // both edges
        for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = din;
    endtask

    task automatic check_all();
        chk("level_rise", level0, m_level);
        chk("pulse_rise", pulse0, m_p0);
        chk("any_rise",   any0,   |m_p0);
        chk("level_both", level2, m_level);
        chk("pulse_both", pulse2, m_p2);
        chk("any_both",   any2,   |m_p2);
    endtask

    // One clock: inputs already stable; model advances on the same edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_clk();
        else model_reset();
        #1;
        check_all();
    endtask

    // Run n cycles with a tick every per cycles.
    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tick = ((i % per) == 0);
            cyc();
        end
    endtask

    int seen_rise, seen_both;

    initial begin
        model_reset();
        tick = 1'b1;
        // Held in reset: outputs must be idle.
        for (int i = 0; i < 3; i++) cyc();
        rst_n = 1'b1;
        // din=0, tick every clk: nothing may appear.
        run(20, 1);
        chk("t1_level", level0, 4'h0);
        chk("t1_pulse", pulse0, 4'h0);

        // Single rising step on channel 0, slow ticks, then fall.
        din[0] = 1'b1;
        run(60, 8);
        chk("t2_level_hi", level0[0], 1'b1);
        din[0] = 1'b0;
        run(60, 8);
        chk("t2_level_lo", level0[0], 1'b0);

        // Glitch on channel 1: 3 ticks high, then a 4-tick-plus-sync pulse.
        din[1] = 1'b1;
        run(3 * 4, 4);
        din[1] = 1'b0;
        run(30, 4);
        chk("t3_glitch_level", level0[1], 1'b0);
        din[1] = 1'b1;
        run(SS + 4 * 4 + 2, 4);
        din[1] = 1'b0;
        run(40, 4);

        // Channel 2 up then down, each held 6 ticks.
        din[2] = 1'b1;
        run(6 * 4, 4);
        din[2] = 1'b0;
        run(6 * 4 + 10, 4);

        // Four-channel step with pattern 1011: all accepted in the same cycle.
        din = 4'b1011;
        seen_rise = 0;
        for (int i = 0; i < 100 && seen_rise == 0; i++) begin
            tick = ((i % 2) == 0);
            cyc();
            if (pulse0 != '0) begin
                seen_rise = 1;
                chk("t5_pulse_pattern", pulse0, 4'b1011);
                chk("t5_any", any0, 1'b1);
            end
        end
        chk("t5_seen", seen_rise, 1);
        run(4, 2);
        chk("t5_one_clk", pulse0, 4'h0);
        din = 4'b0000;
        run(40, 2);

        // Reset two ticks into a 0->1 change, release with din still high.
        din[3] = 1'b1;
        run(SS + 2 * 3, 3);
        @(posedge clk);
        model_clk();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_async_level", level0, 4'h0);
        run(3, 1);
        rst_n = 1'b1;
        seen_rise = 0;
        seen_both = 0;
        for (int i = 0; i < 60; i++) begin
            tick = ((i % 3) == 0);
            cyc();
            if (pulse0[3]) seen_rise++;
            if (pulse2[3]) seen_both++;
        end
        chk("t6_rise_once", seen_rise, 1);
        chk("t6_both_once", seen_both, 1);

        // Random phase: sparse input flips and random ticks.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 19) == 0) din[c] = ~din[c];
            tick = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
